// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with parity/stop checks and a valid/ready byte output
module uart_rx #(
  parameter int CLK_FREQ = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic [31:0] baudrate,
  input  logic [1:0]  stop_bits,
  input  logic        parity_en,
  input  logic        parity_type,
  output logic [7:0]  data,
  output logic        valid,
  input  logic        ready,
  output logic        parity_err,
  output logic        frame_err,
  output logic        overrun
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state, state_next;
  logic        rx_meta, rx_sync, rx_prev;
  logic [31:0] div, half, cnt;
  logic [7:0]  shift;
  logic [2:0]  bit_idx;
  logic        stop_idx;
  logic        perr_acc, ferr_acc;
  logic        fall, tick, two_stop, last_stop, complete;

  assign div       = 32'(CLK_FREQ) / baudrate;
  assign half      = div >> 1;
  assign fall      = rx_prev & ~rx_sync;
  assign tick      = (cnt == 32'd0);
  assign two_stop  = (stop_bits >= 2'd2);
  assign last_stop = ~two_stop | stop_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      state   <= IDLE;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      state   <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    complete   = 1'b0;
    case (state)
      IDLE:   if (fall) state_next = START;
      START:  if (tick) state_next = rx_sync ? IDLE : DATA;
      DATA:   if (tick && bit_idx == 3'd7) state_next = parity_en ? PARITY : STOP;
      PARITY: if (tick) state_next = STOP;
      STOP: begin
        if (tick && last_stop) begin
          state_next = IDLE;
          complete   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit timing and frame assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 32'd0;
      shift    <= 8'd0;
      bit_idx  <= 3'd0;
      stop_idx <= 1'b0;
      perr_acc <= 1'b0;
      ferr_acc <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (fall) cnt <= half - 32'd1;
      end else if (tick) begin
        cnt <= div - 32'd1;
      end else begin
        cnt <= cnt - 32'd1;
      end

      if (tick) begin
        case (state)
          START: begin
            bit_idx  <= 3'd0;
            stop_idx <= 1'b0;
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
          end
          DATA: begin
            shift   <= {rx_sync, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
          PARITY: perr_acc <= ((^shift) ^ rx_sync) != parity_type;
          STOP: begin
            if (!rx_sync) ferr_acc <= 1'b1;
            stop_idx <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // A handshake in the completion cycle frees the slot, so the new frame loads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data       <= 8'd0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (complete) begin
        if (!valid || ready) begin
          data       <= shift;
          parity_err <= perr_acc;
          frame_err  <= ferr_acc | ~rx_sync;
          valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

  localparam int DIV = 217;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic [31:0] baudrate = 32'd115200;
  logic [1:0]  stop_bits = 2'd1;
  logic        parity_en = 1'b0;
  logic        parity_type = 1'b0;
  logic [7:0]  data;
  logic        valid;
  logic        ready = 1'b0;
  logic        parity_err;
  logic        frame_err;
  logic        overrun;

  int checks = 0;
  int failures = 0;
  int ovr_cnt = 0;
  int rise_cnt = 0;
  logic valid_q = 1'b0;
  int base;

  uart_rx #(.CLK_FREQ(25_000_000)) dut (
    .clk(clk), .rst(rst), .rx(rx), .baudrate(baudrate), .stop_bits(stop_bits),
    .parity_en(parity_en), .parity_type(parity_type), .data(data), .valid(valid),
    .ready(ready), .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
  );

  always #20 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (overrun === 1'b1) ovr_cnt++;
      if (valid === 1'b1 && valid_q !== 1'b1) rise_cnt++;
    end
    valid_q = valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    wait_cycles(n);
  endtask

  task automatic send(input logic [7:0] b, input logic pen, input logic pbit,
                      input logic s1, input logic s2, input int nstop);
    drive_bit(1'b0, DIV);
    for (int i = 0; i < 8; i++) drive_bit(b[i], DIV);
    if (pen) drive_bit(pbit, DIV);
    drive_bit(s1, DIV);
    if (nstop == 2) drive_bit(s2, DIV);
    rx = 1'b1;
  endtask

  task automatic consume();
    ready = 1'b1;
    wait_cycles(1);
    ready = 1'b0;
    wait_cycles(1);
  endtask

  initial begin
    wait_cycles(3);
    check("reset_data", 32'(data), 32'h00);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_perr", 32'(parity_err), 32'd0);
    check("reset_ferr", 32'(frame_err), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    wait_cycles(10);

    // 0x41, odd parity, correct parity bit 1
    parity_en = 1'b1; parity_type = 1'b1; stop_bits = 2'd1;
    send(8'h41, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    wait_cycles(20);
    check("odd_ok_data", 32'(data), 32'h41);
    check("odd_ok_valid", 32'(valid), 32'd1);
    check("odd_ok_perr", 32'(parity_err), 32'd0);
    check("odd_ok_ferr", 32'(frame_err), 32'd0);
    ready = 1'b1;
    wait_cycles(1);
    check("handshake_drop", 32'(valid), 32'd0);
    ready = 1'b0;

    // Wrong parity bit
    send(8'h41, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    wait_cycles(20);
    check("bad_par_data", 32'(data), 32'h41);
    check("bad_par_perr", 32'(parity_err), 32'd1);
    check("bad_par_ferr", 32'(frame_err), 32'd0);
    consume();

    // No parity
    parity_en = 1'b0;
    send(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    wait_cycles(20);
    check("nopar_data", 32'(data), 32'hA5);
    check("nopar_valid", 32'(valid), 32'd1);
    check("nopar_perr", 32'(parity_err), 32'd0);
    check("nopar_ferr", 32'(frame_err), 32'd0);
    consume();

    // Two stop bits, second one low
    stop_bits = 2'd2;
    send(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    wait_cycles(20);
    check("stop2_data", 32'(data), 32'h5A);
    check("stop2_ferr", 32'(frame_err), 32'd1);
    check("stop2_perr", 32'(parity_err), 32'd0);
    consume();
    stop_bits = 2'd1;

    // Break: rx low for 12 bit times yields exactly one frame
    base = rise_cnt;
    drive_bit(1'b0, 12 * DIV);
    check("break_valid", 32'(valid), 32'd1);
    check("break_data", 32'(data), 32'h00);
    check("break_ferr", 32'(frame_err), 32'd1);
    check("break_frames", 32'(rise_cnt - base), 32'd1);
    check("break_overrun", 32'(ovr_cnt), 32'd0);
    drive_bit(1'b1, 3 * DIV);
    consume();
    wait_cycles(DIV);
    check("break_after_valid", 32'(valid), 32'd0);

    // Glitch shorter than half a bit
    base = rise_cnt;
    drive_bit(1'b0, 50);
    drive_bit(1'b1, 2 * DIV);
    check("glitch_valid", 32'(valid), 32'd0);
    check("glitch_frames", 32'(rise_cnt - base), 32'd0);
    send(8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    wait_cycles(20);
    check("post_glitch_data", 32'(data), 32'h55);
    check("post_glitch_valid", 32'(valid), 32'd1);
    consume();

    // Back-to-back frames with consumer stalled
    send(8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    send(8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    wait_cycles(20);
    check("ovr_data_kept", 32'(data), 32'h11);
    check("ovr_valid", 32'(valid), 32'd1);
    check("ovr_pulses", 32'(ovr_cnt), 32'd1);
    ready = 1'b1;
    base = rise_cnt;
    wait_cycles(5);
    send(8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    wait_cycles(20);
    check("ready_data", 32'(data), 32'h33);
    check("ready_frames", 32'(rise_cnt - base), 32'd1);
    check("ready_no_ovr", 32'(ovr_cnt), 32'd1);
    check("ready_valid_drop", 32'(valid), 32'd0);
    ready = 1'b0;

    // Reset in the middle of data bit 4
    base = rise_cnt;
    drive_bit(1'b0, DIV);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, DIV);
    drive_bit(1'b0, DIV / 2);
    rx = 1'b1;
    rst = 1'b1;
    wait_cycles(3);
    check("midrst_data", 32'(data), 32'h00);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_perr", 32'(parity_err), 32'd0);
    check("midrst_ferr", 32'(frame_err), 32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    wait_cycles(12 * DIV);
    check("midrst_no_frame", 32'(rise_cnt - base), 32'd0);
    send(8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    wait_cycles(20);
    check("post_rst_data", 32'(data), 32'hC3);
    check("post_rst_valid", 32'(valid), 32'd1);
    check("post_rst_ferr", 32'(frame_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver: the receive-side counterpart of `uart_tx`, sharing its runtime line configuration (baud rate, stop bits, parity enable/type). It oversamples the `rx` pin with a per-bit counter, recovers 8-bit LSB-first frames, checks parity and stop bits, and presents each byte on a valid/ready output handshake. It sits between the board UART RX pin and any byte consumer in the `clk25` domain.

## Interface
- `CLK_FREQ`, default 25_000_000: system clock frequency in Hz, used to derive the bit period.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial line, asynchronous to `clk`; idles high.
- `baudrate`  in  32  bit rate in baud; static while not idle.
- `stop_bits`  in  2  stop bits to check: 2 means two; 1 and 0 mean one; 3 means two.
- `parity_en`  in  1  1 means a parity bit follows the data bits.
- `parity_type`  in  1  0 is even parity, 1 is odd parity.
- `data`  out  8  received byte.
- `valid`  out  1  `data` and the error flags hold an unconsumed frame.
- `ready`  in  1  consumer accepts the frame when `valid && ready`.
- `parity_err`  out  1  parity mismatch for the frame on `data`; qualified by `valid`.
- `frame_err`  out  1  a stop bit was sampled low; qualified by `valid`.
- `overrun`  out  1  one-cycle pulse: a frame completed while `valid` was still high.

## Operation
- `rx` passes through a 2-FF synchronizer, then a 1-cycle delayed copy is used for falling-edge detection. Only the synchronized signal is sampled.
- DIV = CLK_FREQ / baudrate, with integer truncation. HALF = DIV / 2. At 25 MHz and 115200 baud, DIV = 217 and HALF = 108. The bit counter is 32 bits wide and counts down from DIV-1 or HALF-1 to 0.
- FSM states:
  - IDLE: waits for a falling edge on synchronized rx, then loads HALF-1 and goes to START.
  - START: at count 0, samples rx. If high, this is a false start and the FSM returns to IDLE. If low, it loads DIV-1, clears the bit index, and goes to DATA.
  - DATA: at each count 0, shifts the rx sample into the MSB of the shift register, so bit 0 arrives first. After 8 samples it goes to PARITY if `parity_en`, otherwise to STOP.
  - PARITY: at count 0, samples the parity bit. Error if (^shift ^ sample) != `parity_type`.
  - STOP: samples one or two stop bits, each at count 0 spaced DIV apart. Any low sample sets the frame error.
- Completion happens on the last stop sample. The FSM goes straight to IDLE, without waiting out the rest of the stop bit, so back-to-back start edges are caught.
- Completion while `valid` = 0: load `data`, `parity_err` and `frame_err`, and set `valid`.
- Completion while `valid` = 1: pulse `overrun` for 1 cycle and drop the new frame. The old `data` and flags are unchanged.
- `valid` clears on the cycle after `valid && ready`. If the handshake and a completion fall in the same cycle, the new frame loads, `valid` stays 1, and there is no overrun.
- A frame with a parity or frame error is still delivered, with its flags set. A break condition (rx low throughout) delivers `data` = 0x00 with `frame_err` = 1. The receiver then waits in IDLE for the next falling edge, which needs rx to return high first.
- Configuration inputs are sampled live. Changing them mid-frame is undefined.

## Timing
- Reset values: `data` = 0x00, `valid` = 0, `parity_err` = 0, `frame_err` = 0, `overrun` = 0, FSM = IDLE, and both synchronizer flops = 1.
- Reset can assert at any time, including mid-frame. The frame in progress is discarded and no `valid` is produced.
- The start edge is seen 3 `clk` cycles after the `rx` pin falls: 2 synchronizer flops plus the edge register.
- The start check happens HALF cycles after detection. Data bit k is sampled (k+1)·DIV cycles after that check, for k = 0 to 7. The parity bit and the stop bits follow, each DIV cycles apart.
- `valid` rises 1 cycle after the last stop sample. Total latency from the pin's start edge to `valid` is about (frame_bits − 0.5)·DIV + 4 cycles.
- `data` and flags are stable whenever `valid` = 1 and change only when a frame loads.

## Test plan
- Send 0x41 with odd parity (parity bit 1) and 1 stop bit at 115200 baud. Expect `data` = 0x41, `valid` = 1, `parity_err` = 0, `frame_err` = 0. Hold `ready` = 1 and check `valid` drops after 1 cycle.
- Send 0x41 with odd parity enabled but the parity bit driven 0. Expect `data` = 0x41 and `parity_err` = 1. With `parity_en` = 0, send 0xA5 and expect `data` = 0xA5 with no errors.
- Set `stop_bits` = 2 and drive the second stop bit low. Expect `frame_err` = 1. Separately, hold rx low for 12 bit times and expect `data` = 0x00, `frame_err` = 1, and only one frame until rx returns high.
- Send a low glitch on rx of 50 cycles (less than HALF). Expect no `valid`, the FSM back in IDLE, and a following 0x55 frame received correctly.
- Hold `ready` = 0 and send 0x11 then 0x22 back to back. Expect `data` = 0x11 retained and one `overrun` pulse. Then raise `ready` and send 0x33. Expect `data` = 0x33 with no overrun.
- Assert `rst` midway through data bit 4. Expect all outputs at their reset values and no `valid`, then a clean reception of the next frame, 0xC3.
